ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clk cycles PS/2 clock is held low before a transfer (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, max clk cycles between consecutive device clock falling edges, or waiting for bus idle (20 ms at 50 MHz).
REQ-003 clk  input  1  system clock; one clock domain, all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tx_data  input  8  command/data byte to send to the keyboard (e.g. ED LEDs, FF reset).
REQ-006 tx_valid  input  1  request to send tx_data.
REQ-007 tx_ready  output  1  high only in IDLE; transfer accepted on clk edge where tx_valid and tx_ready are both high.
REQ-008 tx_done  output  1  one-cycle pulse: byte sent and device ACK received.
REQ-009 tx_error  output  1  one-cycle pulse: timeout or missing ACK; tx_done not pulsed for that transfer.
REQ-010 busy  output  1  high from acceptance until tx_done/tx_error; gates the scan-code receiver.
REQ-011 ps2_clk_in, ps2_data_in  input  1 each  raw asynchronous PS/2 line levels.
REQ-012 ps2_clk_oe, ps2_data_oe  output  1 each  1 = pull line low (open drain), 0 = release.

Function
REQ-013 ps2_clk_in/ps2_data_in SHALL pass through 2-flop synchronisers; falling edge = previous synced clock 1, current 0.
REQ-014 States SHALL be IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE.
REQ-015 IDLE: both oe low, tx_ready high; on accept latch tx_data, compute odd parity (parity = ~^tx_data), go INHIBIT next cycle.
REQ-016 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe=1 asserted in the last INHIBIT cycle (start bit 0).
REQ-017 REQUEST: ps2_clk_oe=0, ps2_data_oe held 1; edge counter cleared; go SHIFT.
REQ-018 SHIFT: on falling edges 1..8 drive ps2_data_oe = ~data bit 0..7 (LSB first); edge 9 drives ~parity; edge 10 releases data (stop bit 1) and goes ACK.
REQ-019 ACK: on falling edge 11 sample synced data; 0 = ACK -> WAIT_IDLE; 1 -> tx_error pulse, IDLE.
REQ-020 WAIT_IDLE: when synced clock and data both 1, pulse tx_done, go IDLE.
REQ-021 Timeout counter SHALL clear on every falling edge and state entry; reaching TIMEOUT_CYCLES in REQUEST/SHIFT/ACK/WAIT_IDLE: release both lines, pulse tx_error, go IDLE.
REQ-022 tx_valid while busy SHALL be ignored (no queuing); tx_data changes after acceptance SHALL not affect the transfer.
REQ-023 tx_done and tx_error SHALL never assert in the same cycle; busy deasserts the cycle the pulse is high.
REQ-024 Counter widths SHALL be $clog2 of the larger parameter + 1; edge counter 4 bits, values 0..11, no wrap.

Reset
REQ-025 reset SHALL immediately: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_error=0, busy=0, tx_ready=1 once reset is released, synchronisers to 1.
REQ-026 reset mid-transfer SHALL release both lines within the same cycle (asynchronous), without a tx_done/tx_error pulse.

Structure
REQ-027 Package ps2_pkg SHALL hold the state enum and command constants (CMD_SET_LEDS 8'hED, CMD_RESET 8'hFF, CMD_ENABLE 8'hF4, RSP_ACK 8'hFA).
REQ-028 Sub-module ps2_line_sync (2-flop sync + falling-edge strobe) SHALL be instantiated here and reusable by the receiver path.

Verification
REQ-029 Send 8'hED with a device model clocking at 12.5 kHz: data line bits after start = 1,0,1,1,0,1,1,1, parity 1, stop 1; ACK low -> one tx_done, no tx_error.
REQ-030 Send 8'h01 -> parity bit 0; 8'h00 -> parity bit 1; both complete with tx_done.
REQ-031 Device never clocks -> exactly one tx_error TIMEOUT_CYCLES after REQUEST entry, both oe 0 afterward, tx_ready 1.
REQ-032 Device holds data high on edge 11 -> tx_error pulse, no tx_done.
REQ-033 Assert reset during SHIFT after edge 4 -> both oe 0 same cycle; post-reset send 8'hFF completes normally.
REQ-034 tx_valid held high continuously with changing tx_data -> only first byte sent until tx_done; next accepted the cycle after IDLE re-entry; ps2_clk_oe low time = INHIBIT_CYCLES exactly.

Source files
------------

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host path: the host transmit state
// encoding, the common keyboard command/response bytes and the frame edge
// numbering used by the transmitter. Imported by ps2_line_sync and
// ps2_host_tx. Intended to be reused by the scan-code receiver path.
// ----------------------------------------------------------------------------
package ps2_pkg;

  // Host transmit FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQUEST   = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_t;

  // Keyboard commands and responses.
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Device clock falling-edge numbers within a host-to-device frame.
  // Edges 1..8 carry data bits, then parity, stop release, device ACK.
  localparam logic [3:0] EDGE_LAST_DATA = 4'd8;
  localparam logic [3:0] EDGE_PARITY    = 4'd9;
  localparam logic [3:0] EDGE_STOP      = 4'd10;
  localparam logic [3:0] EDGE_ACK       = 4'd11;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ----------------------------------------------------------------------------
// ps2_line_sync
// Two-flop synchroniser for one raw PS/2 line plus a falling-edge strobe.
// The line idles high, so every flop resets to 1; this keeps a reset from
// manufacturing a false falling edge.
//
// Ports
//   clk        system clock (rising edge)
//   reset      asynchronous, active-high reset
//   line_in    raw asynchronous line level
//   line_sync  synchronised line level
//   line_fall  one-cycle strobe: previous synced level 1, current 0
// ----------------------------------------------------------------------------
module ps2_line_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign line_sync = sync;
  assign line_fall = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. Sends one command byte to a keyboard:
// inhibits the bus by holding the clock low, requests to send by pulling
// data low (start bit), then shifts the byte LSB first, odd parity and the
// stop bit on the device-generated clock, and finally checks the device ACK.
//
// Parameters
//   INHIBIT_CYCLES  clk cycles the PS/2 clock is held low before a transfer
//   TIMEOUT_CYCLES  max clk cycles between device clock falling edges, or
//                   waiting for the bus to return idle
//
// Ports
//   clk, reset                 system clock, async active-high reset
//   tx_data, tx_valid          byte to send and request (accepted in IDLE)
//   tx_ready                   high only in IDLE
//   tx_done                    one-cycle pulse: byte sent and ACK seen
//   tx_error                   one-cycle pulse: timeout or missing ACK
//   busy                       high from acceptance until the done/error pulse
//   ps2_clk_in, ps2_data_in    raw PS/2 line levels
//   ps2_clk_oe, ps2_data_oe    1 = pull line low, 0 = release (open drain)
// ----------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                             : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  // Count at which the start bit goes out so it overlaps the final
  // inhibit cycle only. Unreachable (and unused) when INHIBIT_CYCLES is 1.
  localparam logic [CNT_W-1:0] INH_DATA = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic             START_AT_ACCEPT = (INHIBIT_CYCLES == 1);

  ps2_tx_state_t    state;
  logic [CNT_W-1:0] cyc_cnt;
  logic [3:0]       edge_cnt;
  logic [7:0]       tx_byte;
  logic             tx_parity;

  logic clk_sync;
  logic clk_fall;
  logic data_sync;
  logic data_fall_unused;

  logic accept;
  logic waiting;
  logic timed_out;

  ps2_line_sync u_clk_sync (
    .clk       (clk),
    .reset     (reset),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .line_fall (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk       (clk),
    .reset     (reset),
    .line_in   (ps2_data_in),
    .line_sync (data_sync),
    .line_fall (data_fall_unused)
  );

  assign tx_ready = (state == IDLE);
  assign accept   = tx_ready & tx_valid;

  // States in which the host depends on the device making progress.
  assign waiting   = (state == REQUEST) || (state == SHIFT) ||
                     (state == ACK)     || (state == WAIT_IDLE);
  assign timed_out = waiting && (cyc_cnt == TO_LAST);

  // Byte and parity are captured once at acceptance so later changes on
  // tx_data cannot disturb the frame in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_byte   <= tx_data;
      tx_parity <= odd_parity(tx_data);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      edge_cnt    <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;

      if (timed_out) begin
        // Device stopped clocking or never released the bus: give the
        // lines back and report the failure.
        state       <= IDLE;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx_error    <= 1'b1;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            if (tx_valid) begin
              state       <= INHIBIT;
              cyc_cnt     <= '0;
              ps2_clk_oe  <= 1'b1;
              ps2_data_oe <= START_AT_ACCEPT;
              busy        <= 1'b1;
            end
          end

          INHIBIT: begin
            if (cyc_cnt == INH_LAST) begin
              // Release the clock with data still low: request-to-send.
              state      <= REQUEST;
              cyc_cnt    <= '0;
              ps2_clk_oe <= 1'b0;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
              if (!START_AT_ACCEPT && (cyc_cnt == INH_DATA)) begin
                ps2_data_oe <= 1'b1;
              end
            end
          end

          REQUEST: begin
            // One-cycle setup; the timeout keeps running from REQUEST entry
            // because this and SHIFT together are one wait for edge 1.
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            edge_cnt    <= '0;
            cyc_cnt     <= cyc_cnt + 1'b1;
            state       <= SHIFT;
          end

          SHIFT: begin
            if (clk_fall) begin
              cyc_cnt  <= '0;
              edge_cnt <= edge_cnt + 4'd1;
              if (edge_cnt < EDGE_LAST_DATA) begin
                ps2_data_oe <= ~tx_byte[edge_cnt[2:0]];
              end else if (edge_cnt == EDGE_LAST_DATA) begin
                ps2_data_oe <= ~tx_parity;
              end else begin
                // Edge 10: stop bit is a released (high) line.
                ps2_data_oe <= 1'b0;
                edge_cnt    <= EDGE_STOP;
                state       <= ACK;
              end
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end

          ACK: begin
            if (clk_fall) begin
              cyc_cnt  <= '0;
              edge_cnt <= EDGE_ACK;
              if (!data_sync) begin
                state <= WAIT_IDLE;
              end else begin
                state    <= IDLE;
                tx_error <= 1'b1;
                busy     <= 1'b0;
              end
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end

          WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
              state   <= IDLE;
              tx_done <= 1'b1;
              busy    <= 1'b0;
            end else if (clk_fall) begin
              cyc_cnt <= '0;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end

          default: begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
// Bench for ps2_host_tx with a behavioural keyboard on open-drain lines.
// Bus timing is scaled down (short inhibit, timeout and device clock period)
// to keep the run short.
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH      = 50;
  localparam int TO       = 300;
  localparam int DEV_HALF = 30;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       par;
    int         exp_done;
    int         exp_err;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic [7:0] tx_req;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       busy;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  logic       dev_clk;
  logic       dev_data;
  logic       scramble;
  logic [7:0] scram_val = 8'h10;

  logic       cap_start;
  logic [9:0] cap_bits;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int busy_viol = 0;
  int run = 0;
  int last_run = 0;
  int ovl = 0;
  int last_ovl = 0;

  // Open-drain bus: a line is low if either side pulls it.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;
  assign tx_data     = scramble ? scram_val : tx_req;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .busy        (busy),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) scram_val <= scram_val + 8'h37;

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    if ((tx_done || tx_error) && busy) busy_viol <= busy_viol + 1;
    if (ps2_clk_oe) begin
      run <= run + 1;
      if (ps2_data_oe) ovl <= ovl + 1;
    end else if (run != 0) begin
      last_run <= run;
      last_ovl <= ovl;
      run      <= 0;
      ovl      <= 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int w;
    w = 0;
    @(negedge clk);
    while (!tx_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) fail_timeout("send_ready");
    tx_req   = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_req   = ~d;
  endtask

  // Keyboard model: waits for request-to-send, then generates n clock
  // pulses, sampling the host data line on each rising edge. Before pulse
  // 11 it pulls data low when ack is set. Returns right after the last rise.
  task automatic dev_run(input int n, input logic ack);
    int w;
    w = 0;
    cap_start = 1'b1;
    cap_bits  = '0;
    while (!(!ps2_clk_oe && ps2_data_oe) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      fail_timeout("dev_request");
      return;
    end
    cap_start = ps2_data_in;
    repeat (10) @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      if (k == 11) begin
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (5) @(posedge clk);
      end
      dev_clk = 1'b0;
      repeat (DEV_HALF) @(posedge clk);
      dev_clk = 1'b1;
      if (k <= 10) cap_bits[k-1] = ps2_data_in;
      if (k == 11) dev_data = 1'b1;
      if (k < n) repeat (DEV_HALF) @(posedge clk);
    end
  endtask

  task automatic wait_pulse(input int snap);
    int w;
    w = 0;
    @(negedge clk);
    while ((done_cnt + err_cnt) == snap && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) fail_timeout("pulse_wait");
  endtask

  task automatic run_vec(input vec_t v);
    int d0;
    int e0;
    send_byte(v.data);
    d0 = done_cnt;
    e0 = err_cnt;
    dev_run(11, v.ack);
    wait_pulse(d0 + e0);
    repeat (2) @(negedge clk);
    chk("start_bit", int'(cap_start), 0);
    chk("data_byte", int'(cap_bits[7:0]), int'(v.data));
    chk("parity_bit", int'(cap_bits[8]), int'(v.par));
    chk("stop_bit", int'(cap_bits[9]), 1);
    chk("done_count", done_cnt - d0, v.exp_done);
    chk("error_count", err_cnt - e0, v.exp_err);
    chk("ready_after", int'(tx_ready), 1);
    chk("clk_oe_after", int'(ps2_clk_oe), 0);
    chk("data_oe_after", int'(ps2_data_oe), 0);
    chk("inhibit_len", last_run, INH);
    chk("start_overlap", last_ovl, 1);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t vff;
    int d0;
    int e0;
    int c0;
    int w;

    vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
    vecs[1] = '{8'h01, 1'b1, 1'b0, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1, 0};
    vecs[3] = '{8'hF4, 1'b1, 1'b0, 1, 0};
    vecs[4] = '{8'hED, 1'b0, 1'b1, 0, 1};
    vff     = '{8'hFF, 1'b1, 1'b1, 1, 0};

    reset    = 1'b1;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tx_valid = 1'b0;
    tx_req   = 8'h00;
    scramble = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_data_oe", int'(ps2_data_oe), 0);
    chk("rst_done", int'(tx_done), 0);
    chk("rst_error", int'(tx_error), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(tx_ready), 1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Device never clocks: timeout counted from REQUEST entry.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hF4);
    w = 0;
    while (ps2_clk_oe && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) fail_timeout("to_request");
    c0 = cyc;
    w = 0;
    while (!tx_error && w < 2 * TO) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2 * TO) fail_timeout("to_error");
    chk("timeout_latency", cyc - c0, TO);
    repeat (3) @(negedge clk);
    chk("timeout_errors", err_cnt - e0, 1);
    chk("timeout_dones", done_cnt - d0, 0);
    chk("timeout_clk_oe", int'(ps2_clk_oe), 0);
    chk("timeout_data_oe", int'(ps2_data_oe), 0);
    chk("timeout_ready", int'(tx_ready), 1);

    // Reset during SHIFT after edge 4 of 8'h00 (bit 3 = 0, data pulled).
    send_byte(8'h00);
    dev_run(4, 1'b1);
    @(negedge clk);
    chk("pre_rst_data_oe", int'(ps2_data_oe), 1);
    d0 = done_cnt;
    e0 = err_cnt;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_clk_oe", int'(ps2_clk_oe), 0);
    chk("midrst_data_oe", int'(ps2_data_oe), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_ready", int'(tx_ready), 1);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_no_error", err_cnt - e0, 0);
    run_vec(vff);

    // tx_valid held high with tx_data changing every cycle.
    d0 = done_cnt;
    @(negedge clk);
    tx_req   = 8'hF4;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    scramble = 1'b1;
    @(negedge clk);
    chk("hold_busy", int'(busy), 1);
    dev_run(11, 1'b1);
    w = 0;
    while (!tx_done && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) fail_timeout("hold_done");
    scramble = 1'b0;
    tx_req   = 8'hFA;
    @(negedge clk);
    chk("hold_next_accept", int'(ps2_clk_oe), 1);
    tx_valid = 1'b0;
    chk("hold_first_byte", int'(cap_bits[7:0]), 8'hF4);
    chk("hold_single_done", done_cnt - d0, 1);
    chk("hold_inhibit_len", last_run, INH);
    e0 = err_cnt;
    d0 = done_cnt;
    dev_run(11, 1'b1);
    wait_pulse(d0 + e0);
    repeat (2) @(negedge clk);
    chk("hold_second_byte", int'(cap_bits[7:0]), 8'hFA);
    chk("hold_second_par", int'(cap_bits[8]), 1);
    chk("hold_second_done", done_cnt - d0, 1);
    chk("hold_inhibit_len2", last_run, INH);

    chk("never_done_and_error", both_cnt, 0);
    chk("busy_low_on_pulse", busy_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
